// File: rtl/lfsr_height_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_height_gen_if
// Description : Request / seed / result bundle of the wall-height generator.
//               The master side issues requests and seeds; the slave side
//               (the generator) reports busy and returns heights.
// Revision    : 1.0 - initial release
// ============================================================================
interface lfsr_height_gen_if #(
    parameter int LFSR_W = 16,
    parameter int OUT_W  = 8
);
    logic              req;
    logic              seed_load;
    logic [LFSR_W-1:0] seed_val;
    logic              busy;
    logic              height_valid;
    logic [OUT_W-1:0]  height;

    modport master (
        output req, seed_load, seed_val,
        input  busy, height_valid, height
    );

    modport slave (
        input  req, seed_load, seed_val,
        output busy, height_valid, height
    );
endinterface
`default_nettype wire

// File: rtl/lfsr_height_gen.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_height_gen
// Description : Galois-LFSR wall-height source. Each accepted request runs
//               SHIFTS LFSR steps, then scales the upper OUT_W state bits into
//               [MIN_H, MIN_H+RANGE-1] and pulses height_valid for one cycle.
//               Optional macro HEIGHT_SMOOTH_EN limits the change between
//               consecutive heights to MAX_STEP.
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr_height_gen #(
    parameter int               LFSR_W   = 16,
    parameter logic [LFSR_W-1:0] TAPS    = 16'hB400,
    parameter logic [LFSR_W-1:0] SEED    = 16'hACE1,
    parameter int               OUT_W    = 8,
    parameter int               SHIFTS   = 16,
    parameter int               MIN_H    = 16,
    parameter int               RANGE    = 96,
    parameter int               MAX_STEP = 24
) (
    input  wire logic           clk,
    input  wire logic           reset,
    lfsr_height_gen_if.slave    bus
);

    // Full-width product: no bits are lost before the >> OUT_W.
    localparam int PROD_W = OUT_W + $clog2(RANGE) + 1;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SHIFT = 2'd1;
    localparam logic [1:0] c_SCALE = 2'd2;

    logic [1:0]        state_q,  state_d;
    logic [LFSR_W-1:0] lfsr_q,   lfsr_d;
    logic [7:0]        cnt_q,    cnt_d;
    logic [OUT_W-1:0]  height_q, height_d;
    logic              valid_q,  valid_d;

    logic [LFSR_W-1:0] w_step;
    logic [LFSR_W-1:0] w_seed;
    logic [OUT_W-1:0]  w_sample;
    logic [PROD_W-1:0] w_prod;
    logic [PROD_W-1:0] w_scaled;
    logic [OUT_W-1:0]  w_raw;
    logic [OUT_W-1:0]  w_new;

    // One Galois step, seed lock-up guard and sample scaling.
    always_comb begin
        w_step   = lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS) : (lfsr_q >> 1);
        w_seed   = (bus.seed_val == '0) ? {{(LFSR_W-1){1'b0}}, 1'b1} : bus.seed_val;
        w_sample = lfsr_q[LFSR_W-1 -: OUT_W];
        w_prod   = PROD_W'(w_sample) * PROD_W'(RANGE);
        w_scaled = w_prod >> OUT_W;
        w_raw    = OUT_W'(MIN_H) + OUT_W'(w_scaled);
    end

`ifdef HEIGHT_SMOOTH_EN
    localparam int SW = OUT_W + 2;

    logic signed [SW-1:0] w_prev_s;
    logic signed [SW-1:0] w_clamp;

    // Limit the step from the previous height, then keep inside the legal range.
    always_comb begin
        w_prev_s = $signed({2'b00, height_q});
        w_clamp  = $signed({2'b00, w_raw});
        if (w_clamp > w_prev_s + $signed(SW'(MAX_STEP)))
            w_clamp = w_prev_s + $signed(SW'(MAX_STEP));
        if (w_clamp < w_prev_s - $signed(SW'(MAX_STEP)))
            w_clamp = w_prev_s - $signed(SW'(MAX_STEP));
        if (w_clamp < $signed(SW'(MIN_H)))
            w_clamp = $signed(SW'(MIN_H));
        if (w_clamp > $signed(SW'(MIN_H + RANGE - 1)))
            w_clamp = $signed(SW'(MIN_H + RANGE - 1));
        w_new = w_clamp[OUT_W-1:0];
    end
`else
    // Raw scaled sample goes straight to the height register.
    always_comb begin
        w_new = w_raw;
    end
`endif

    // Next-state logic: seed load overrides everything, then IDLE/SHIFT/SCALE.
    always_comb begin
        state_d  = state_q;
        lfsr_d   = lfsr_q;
        cnt_d    = cnt_q;
        height_d = height_q;
        valid_d  = 1'b0;
        if (bus.seed_load) begin
            lfsr_d  = w_seed;
            state_d = c_IDLE;
            cnt_d   = 8'd0;
        end else begin
            case (state_q)
                c_IDLE: begin
                    if (bus.req) begin
                        state_d = c_SHIFT;
                        cnt_d   = 8'd0;
                    end
                end
                c_SHIFT: begin
                    lfsr_d = w_step;
                    cnt_d  = cnt_q + 8'd1;
                    if (cnt_q == 8'(SHIFTS - 1))
                        state_d = c_SCALE;
                end
                c_SCALE: begin
                    height_d = w_new;
                    valid_d  = 1'b1;
                    state_d  = c_IDLE;
                end
                default: begin
                    state_d = c_IDLE;
                end
            endcase
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= c_IDLE;
            lfsr_q   <= SEED;
            cnt_q    <= 8'd0;
            height_q <= OUT_W'(MIN_H);
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            cnt_q    <= cnt_d;
            height_q <= height_d;
            valid_q  <= valid_d;
        end
    end

    assign bus.busy         = (state_q != c_IDLE);
    assign bus.height_valid = valid_q;
    assign bus.height       = height_q;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_height_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_lfsr_height_gen
// Description : Scoreboard bench for lfsr_height_gen. Instance A uses default
//               parameters, instance B uses SHIFTS=1. Expected heights come
//               from an arithmetic reference model and are queued at request
//               time; monitors pop them on every height_valid pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lfsr_height_gen;

    localparam int          LW       = 16;
    localparam logic [15:0] TAPS     = 16'hB400;
    localparam logic [15:0] SEED     = 16'hACE1;
    localparam int          MIN_H    = 16;
    localparam int          RANGE    = 96;
    localparam int          MAX_STEP = 24;
    localparam int          SH_A     = 16;
    localparam int          SH_B     = 1;
`ifdef HEIGHT_SMOOTH_EN
    localparam int          FIRST_H  = 40;
`else
    localparam int          FIRST_H  = 83;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    lfsr_height_gen_if #(.LFSR_W(16), .OUT_W(8)) a_if ();
    lfsr_height_gen_if #(.LFSR_W(16), .OUT_W(8)) b_if ();

    lfsr_height_gen #(.SHIFTS(SH_A)) u_dut_a (.clk(clk), .reset(reset), .bus(a_if.slave));
    lfsr_height_gen #(.SHIFTS(SH_B)) u_dut_b (.clk(clk), .reset(reset), .bus(b_if.slave));

    int n_tests = 0;
    int n_fail  = 0;
    int qa[$];
    int qb[$];
    logic [15:0] ma_lfsr, mb_lfsr;
    int          ma_h, mb_h;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: LFSR rule and height scaling as plain arithmetic.
    function automatic logic [15:0] lfsr_adv(input logic [15:0] s, input int n);
        logic [15:0] v = s;
        for (int i = 0; i < n; i++)
            v = v[0] ? ((v >> 1) ^ TAPS) : (v >> 1);
        return v;
    endfunction

    function automatic int height_of(input logic [15:0] s, input int prev);
        int sample, h;
        sample = int'(s) / 256;
        h = MIN_H + (sample * RANGE) / 256;
`ifdef HEIGHT_SMOOTH_EN
        if (h > prev + MAX_STEP) h = prev + MAX_STEP;
        if (h < prev - MAX_STEP) h = prev - MAX_STEP;
        if (h < MIN_H) h = MIN_H;
        if (h > MIN_H + RANGE - 1) h = MIN_H + RANGE - 1;
`else
        if (prev < 0) h = -1;
`endif
        return h;
    endfunction

    function automatic logic [15:0] fix_seed(input logic [15:0] s);
        return (s == 16'h0) ? 16'h0001 : s;
    endfunction

    task automatic push_a();
        ma_lfsr = lfsr_adv(ma_lfsr, SH_A);
        ma_h    = height_of(ma_lfsr, ma_h);
        qa.push_back(ma_h);
    endtask

    task automatic push_b();
        mb_lfsr = lfsr_adv(mb_lfsr, SH_B);
        mb_h    = height_of(mb_lfsr, mb_h);
        qb.push_back(mb_h);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Monitors: every valid pulse consumes one queued expectation.
    always @(negedge clk) begin
        if (a_if.height_valid) begin
            if (qa.size() == 0) chk("a_extra_valid", 1, 0);
            else begin
                chk("a_height", int'(a_if.height), qa.pop_front());
                chk("a_range", int'(a_if.height >= 8'(MIN_H) && a_if.height <= 8'(MIN_H + RANGE - 1)), 1);
            end
        end
        if (b_if.height_valid) begin
            if (qb.size() == 0) chk("b_extra_valid", 1, 0);
            else chk("b_height", int'(b_if.height), qb.pop_front());
        end
    end

    // Hard time limit so the bench always ends.
    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // SHIFTS=1 instance: seed, request, check pulse timing and first value.
    task automatic b_txn(input logic [15:0] seed, input bit check_first);
        b_if.seed_val  = seed;
        b_if.seed_load = 1'b1;
        cycle();
        b_if.seed_load = 1'b0;
        mb_lfsr = fix_seed(seed);
        b_if.req = 1'b1;
        push_b();
        cycle();                       // edge 0
        b_if.req = 1'b0;
        chk("b_busy_e0", int'(b_if.busy), 1);
        chk("b_valid_e0", int'(b_if.height_valid), 0);
        cycle();                       // edge 1
        chk("b_valid_e1", int'(b_if.height_valid), 0);
        cycle();                       // edge 2
        chk("b_valid_e2", int'(b_if.height_valid), 1);
        chk("b_busy_e2", int'(b_if.busy), 0);
        if (check_first) chk("b_first_height", int'(b_if.height), FIRST_H);
        cycle();
    endtask

    initial begin
        reset = 1'b1;
        a_if.req = 1'b0; a_if.seed_load = 1'b0; a_if.seed_val = '0;
        b_if.req = 1'b0; b_if.seed_load = 1'b0; b_if.seed_val = '0;
        ma_lfsr = SEED; mb_lfsr = SEED; ma_h = MIN_H; mb_h = MIN_H;
        repeat (3) cycle();
        reset = 1'b0;
        repeat (2) cycle();
        chk("a_rst_height", int'(a_if.height), MIN_H);
        chk("a_rst_valid", int'(a_if.height_valid), 0);
        chk("a_rst_busy", int'(a_if.busy), 0);
        chk("b_rst_height", int'(b_if.height), MIN_H);

        // First request from the reset seed on A.
        a_if.req = 1'b1;
        push_a();
        cycle();
        a_if.req = 1'b0;
        repeat (SH_A + 1) cycle();
        chk("a_seed_run_busy", int'(a_if.busy), 0);

        // B: seed 1 (known result), then seed 0 which must behave as 1.
        b_txn(16'h0001, 1'b1);
        b_txn(16'h0000, 1'b0);
        b_txn(16'h0000, 1'b0);

        // A: 1000 randomized requests, mostly back-to-back, with ignored
        // requests while busy and occasional idle-time reseeding.
        a_if.req = 1'b1;
        for (int t = 0; t < 1000; t++) begin
            push_a();
            for (int k = 0; k <= SH_A; k++) begin
                cycle();
                a_if.req = 1'($urandom_range(0, 1));
                chk("a_busy_run", int'(a_if.busy), 1);
            end
            cycle();
            chk("a_busy_done", int'(a_if.busy), 0);
            if ($urandom_range(0, 3) == 0) begin
                a_if.req = 1'b0;
                if ($urandom_range(0, 1) == 0) begin
                    a_if.seed_val  = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
                    a_if.seed_load = 1'b1;
                    ma_lfsr = fix_seed(a_if.seed_val);
                    cycle();
                    a_if.seed_load = 1'b0;
                end
                repeat ($urandom_range(1, 3)) cycle();
            end
            a_if.req = 1'b1;
        end
        a_if.req = 1'b0;
        repeat (3) cycle();

        // Abort: seed load in the 5th SHIFT cycle while req stays high.
        a_if.req = 1'b1;
        cycle();                       // edge 0, accepted, then aborted
        repeat (4) cycle();            // edges 1..4
        a_if.seed_val  = 16'hBEEF;
        a_if.seed_load = 1'b1;
        cycle();                       // edge 5: seed wins
        a_if.seed_load = 1'b0;
        ma_lfsr = 16'hBEEF;
        chk("a_abort_busy", int'(a_if.busy), 0);
        chk("a_abort_valid", int'(a_if.height_valid), 0);
        push_a();                      // req still high -> accepted at edge 6
        cycle();
        a_if.req = 1'b0;
        chk("a_after_abort_busy", int'(a_if.busy), 1);
        repeat (SH_A + 2) cycle();

        // Reset in the middle of a request: no valid, state back to reset values.
        a_if.req = 1'b1;
        cycle();
        a_if.req = 1'b0;
        repeat (3) cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        ma_lfsr = SEED; ma_h = MIN_H; mb_lfsr = SEED; mb_h = MIN_H;
        chk("a_midrst_busy", int'(a_if.busy), 0);
        chk("a_midrst_height", int'(a_if.height), MIN_H);
        repeat (SH_A + 2) cycle();
        a_if.req = 1'b1;
        push_a();
        cycle();
        a_if.req = 1'b0;
        repeat (SH_A + 3) cycle();

        chk("a_queue_empty", qa.size(), 0);
        chk("b_queue_empty", qb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lfsr_height_gen.md
Name: lfsr_height_gen

Overview:
- Parametrised pseudo-random wall-height source for the game's obstacle spawner.
- Uses a Galois LFSR of configurable width and taps. Runs a programmable number of shifts per request, then scales the sample into [MIN_H, MIN_H+RANGE-1] and returns it over a req/valid handshake.
- Adds runtime seeding, lock-up protection and optional slew limiting between consecutive walls.

Parameters:
- LFSR_W, 16, LFSR state width (≥ OUT_W, ≥ 4).
- TAPS, 16'hB400, Galois feedback mask, LFSR_W bits wide (x^16+x^14+x^13+x^11+1).
- SEED, 16'hACE1, reset value of LFSR state; must be non-zero.
- OUT_W, 8, height output width.
- SHIFTS, 16, LFSR shifts per request (1..255).
- MIN_H, 16, minimum height.
- RANGE, 96, number of distinct heights; MIN_H+RANGE-1 must be ≤ 2^OUT_W-1.
- MAX_STEP, 24, max |height delta| between consecutive outputs (used only with HEIGHT_SMOOTH_EN).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- req  in  1  request a new height; sampled only in IDLE.
- seed_load  in  1  load seed_val into LFSR.
- seed_val  in  LFSR_W  seed value.
- busy  out  1  high whenever FSM not in IDLE.
- height_valid  out  1  one-cycle pulse: height updated.
- height  out  OUT_W  last generated height, held between pulses.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values:
  - lfsr = SEED
  - height = MIN_H
  - height_valid = 0
  - busy = 0
  - FSM = IDLE
  - shift counter = 0
- LFSR step:
  - if lfsr[0] = 1: lfsr ← (lfsr >> 1) ^ TAPS
  - else: lfsr ← lfsr >> 1
  - The state only changes in SHIFT or on seed_load.
- Lock-up: any load that would make lfsr = 0 (seed_val = 0) loads 1 instead.
- FSM states: IDLE, SHIFT, SCALE.
  - IDLE: req = 1 at a clock edge → SHIFT, counter ← 0, busy rises.
  - SHIFT: each edge performs one LFSR step and counter+1. On the edge performing step number SHIFTS → SCALE.
  - SCALE: one edge.
    - sample = lfsr[LFSR_W-1 -: OUT_W] (upper OUT_W bits).
    - raw = MIN_H + ((sample * RANGE) >> OUT_W).
    - The multiply is full width (OUT_W + clog2(RANGE)+1 bits); no truncation before the shift.
    - height ← raw, height_valid ← 1 for exactly one cycle, → IDLE.
- Latency: the edge sampling req is edge 0; height_valid is high after edge SHIFTS+1.
- Back-to-back: req high in the cycle height_valid is high (FSM already IDLE) is accepted. Throughput is one height per SHIFTS+2 cycles.
- req while busy: ignored, not queued.
- seed_load:
  - Highest priority after reset, in any state.
  - lfsr ← seed_val (zero → 1), FSM → IDLE, counter ← 0, height_valid ← 0.
  - height is retained.
  - Aborts any in-flight request; no valid is produced for it.
  - seed_load and req in the same cycle: seed wins, req dropped.
- reset mid-operation: all state returns to reset values on that edge; no valid.
- height always lies in [MIN_H, MIN_H+RANGE-1].

Optional Feature:
- HEIGHT_SMOOTH_EN defined: in SCALE, the value written to height is the raw value clamped to [height_prev-MAX_STEP, height_prev+MAX_STEP].
  - The clamp is computed signed, then clamped again to [MIN_H, MIN_H+RANGE-1].
  - height_prev is the current height register, which is MIN_H after reset.
- Not defined: height ← raw; MAX_STEP is unused.
- LFSR sequence and timing are identical in both builds.

Test Plan:
- Reset, then 2 idle cycles → height = 16, height_valid = 0, busy = 0, lfsr = 0xACE1.
- SHIFTS=1 override, seed_load with seed_val=0x0001, then req → lfsr = 0xB400 after one step; height_valid pulses after edge 2; height = 16 + (0xB4·96 >> 8) = 16 + 67 = 83.
- seed_load with seed_val=0x0000, then req (SHIFTS=1) → loaded as 0x0001; same result as previous (height = 83); lfsr never 0.
- Default params, 1000 back-to-back requests → every height in [16, 111]; busy high for 17 cycles per request; one valid pulse per request; no missed or extra pulses.
- seed_load asserted on the 5th SHIFT cycle with req held high → no valid for the aborted request; busy low next cycle; next req yields a height identical to a fresh run from that seed.
- HEIGHT_SMOOTH_EN, SHIFTS=1, seed 0x0001, req → raw 83 clamped to 16+24 = 40; height = 40; a second req steps ≤ 24 from 40.
